m_alu_exec_stage: RTL and testbench
===================================

Name: m_alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU preshifter.
- Consumes operand A plus the already-shifted operand B, performs the ALU operation, and maintains the architectural NZCV flag register.
- Presents a registered result to writeback through a valid/ready handshake.
- A 2-entry skid buffer decouples writeback backpressure from the issue side, so input ready never depends combinationally on out_ready.

Parameters:
- XLEN, 32, datapath width of operands and result.
- RD_W, 5, width of the destination register tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  issue side holds a valid operation.
- in_ready  out  1  stage can accept; high iff the skid buffer holds fewer than 2 entries.
- in_op  in  4  e_alu_op operation code.
- in_a  in  XLEN  operand A (unshifted).
- in_b  in  XLEN  operand B, output of the preshifter.
- in_set_flags  in  1  update NZCV from this operation.
- in_rd  in  RD_W  destination register tag.
- flush  in  1  discard all held and incoming operations.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts the head entry.
- out_result  out  XLEN  head entry result.
- out_rd  out  RD_W  head entry destination tag.
- out_wb  out  1  head entry writes a register (0 for ALU_CMP, ALU_TST).
- out_flags  out  4  current flag register {N,Z,C,V}.

Behaviour:
- Reset (async, rst=1):
  - Both buffer entries invalid, so out_valid=0 and in_ready=1.
  - out_result=0, out_rd=0, out_wb=0.
  - Flags cleared: out_flags=4'b0000.
- Input accept = in_valid & in_ready & ~flush.
  - On accept, the result is computed combinationally and written into the buffer tail at the next edge.
  - Latency 1 cycle: an operation accepted in cycle t appears on out_* in t+1 if the buffer was empty.
- Buffer behaviour:
  - 2-entry FIFO with ordered output.
  - Output fire = out_valid & out_ready pops the head.
  - Simultaneous accept and fire with 1 entry held: count stays 1 and the new entry becomes head.
  - in_ready is registered-derived: high when count<2.
- Operations (in_b is used as-is; no further shifting):
  - ALU_ADD: a+b; C = carry-out; V = signed overflow.
  - ALU_ADC: a+b+C.
  - ALU_SUB: a-b; C = NOT borrow (a>=b unsigned).
  - ALU_SBC: a-b-(1-C).
  - ALU_AND, ALU_OR, ALU_XOR: C and V preserved.
  - ALU_MOV: result=b; C and V preserved.
  - ALU_CMP: as SUB, out_wb=0.
  - ALU_TST: as AND, out_wb=0.
  - Undefined op: result=0, out_wb=0, flags not updated.
- Width and arithmetic:
  - Sums computed at XLEN+1 bits; bit XLEN is the carry.
  - N = result[XLEN-1]; Z = (result==0).
- Flag register:
  - Updated at the edge of accept when in_set_flags=1.
  - ADC/SBC read the flag register value before that edge, so back-to-back dependent ops see the prior op's carry.
  - Flags are independent of output backpressure.
- Flush:
  - Clears both buffer entries at the next edge (out_valid=0).
  - The same-cycle input is not accepted and its flag update is suppressed.
  - Flags already committed are retained.
  - A same-cycle output fire is still reported to writeback; downstream ignores it.
- Reset mid-operation: all entries are dropped immediately, asynchronously; there is no partial writeback.

Decomposition:
- p_common gains:
  - typedef enum e_alu_op: ALU_ADD=0, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV, ALU_CMP, ALU_TST.
  - packed struct s_alu_flags {n,z,c,v}.
  - packed struct s_alu_result {result, rd, wb}.
- Sub-module m_alu_skid_buffer: 2-entry valid/ready buffer of s_alu_result.
- The top level holds the combinational ALU function and the flag register.

Test Plan:
- Reset then single op: ADD a=32'h7FFF_FFFF, b=1, set_flags=1.
  - Next cycle: out_valid=1, out_result=32'h8000_0000, out_wb=1.
  - Flags: N=1, Z=0, C=0, V=1.
- Carry chain: ADD a=32'hFFFF_FFFF, b=1, set_flags=1, then ADC a=0, b=0 in the following cycle.
  - First result 0 with Z=1, C=1.
  - Second result 1.
- Backpressure: out_ready=0, issue 3 back-to-back MOVs with b=1,2,3.
  - in_ready drops after 2 accepts; the third op is held.
  - Raise out_ready: outputs 1, 2, 3 in order with no loss or duplication.
- CMP with a=5, b=5: out_wb=0, Z=1, C=1; a register previously holding 9 is unchanged downstream.
- Flush with 2 entries held plus in_valid of SUB set_flags=1 in the same cycle.
  - Next cycle: out_valid=0.
  - out_flags equal to the pre-flush value.
- Async reset asserted mid-stream between clock edges.
  - out_valid=0 and out_flags=0 immediately.
  - in_ready=1 after release.

Source files
------------

// File: rtl/m_alu_exec_stage_pkg.sv
// Shared ALU execute-stage types: operation codes, the NZCV flag layout and
// the result record carried through the writeback skid buffer.
package p_common;

    localparam int unsigned ALU_XLEN = 32;
    localparam int unsigned ALU_RD_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC,
        ALU_SUB,
        ALU_SBC,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_MOV,
        ALU_CMP,
        ALU_TST
    } e_alu_op;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } s_alu_flags;

    typedef struct packed {
        logic [ALU_XLEN-1:0] result;
        logic [ALU_RD_W-1:0] rd;
        logic                wb;
    } s_alu_result;

    // Compare/test only update flags; undefined codes never write back.
    function automatic logic alu_writes_reg(input e_alu_op op);
        case (op)
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC,
            ALU_AND, ALU_OR, ALU_XOR, ALU_MOV: alu_writes_reg = 1'b1;
            default:                          alu_writes_reg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/m_alu_exec_stage_skid_buffer.sv
// Two-entry in-order valid/ready buffer of ALU results; ready depends only on
// held state, never on out_ready.
module m_alu_skid_buffer
    import p_common::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    output logic        ready,
    input  s_alu_result push_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output s_alu_result out_data
);

    s_alu_result head;
    s_alu_result tail;
    logic        head_vld;
    logic        tail_vld;
    logic        pop;
    logic        wr;

    assign ready     = ~tail_vld;
    assign pop       = head_vld & out_ready;
    assign wr        = push & ~tail_vld & ~flush;
    assign out_valid = head_vld;
    assign out_data  = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            head_vld <= 1'b0;
            tail_vld <= 1'b0;
        end else if (flush) begin
            head_vld <= 1'b0;
            tail_vld <= 1'b0;
        end else begin
            case ({wr, pop})
                2'b10: begin
                    if (!head_vld) begin
                        head     <= push_data;
                        head_vld <= 1'b1;
                    end else begin
                        tail     <= push_data;
                        tail_vld <= 1'b1;
                    end
                end
                2'b01: begin
                    head     <= tail;
                    head_vld <= tail_vld;
                    tail_vld <= 1'b0;
                end
                // wr implies the tail is empty, so the new entry replaces the head.
                2'b11: head <= push_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/m_alu_exec_stage.sv
// ALU execute stage: combinational ALU on (A, preshifted B), architectural
// NZCV register, and registered results to writeback via a skid buffer.
module m_alu_exec_stage
    import p_common::*;
#(
    parameter int unsigned XLEN = ALU_XLEN,
    parameter int unsigned RD_W = ALU_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_set_flags,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wb,
    output logic [3:0]      out_flags
);

    e_alu_op         op;
    s_alu_flags      flags_q;
    s_alu_flags      flags_d;
    logic [XLEN-1:0] b_op;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] res;
    logic            cin;
    logic            arith;
    logic            op_def;
    logic            accept;
    logic            buf_ready;
    s_alu_result     push_data;
    s_alu_result     head;

    assign op = e_alu_op'(in_op);

    // Subtraction is a + ~b + cin, so C comes out as NOT borrow directly.
    always_comb begin
        b_op   = in_b;
        cin    = 1'b0;
        arith  = 1'b0;
        op_def = 1'b1;
        res    = '0;
        case (op)
            ALU_ADD:          arith = 1'b1;
            ALU_ADC: begin
                arith = 1'b1;
                cin   = flags_q.c;
            end
            ALU_SUB, ALU_CMP: begin
                arith = 1'b1;
                b_op  = ~in_b;
                cin   = 1'b1;
            end
            ALU_SBC: begin
                arith = 1'b1;
                b_op  = ~in_b;
                cin   = flags_q.c;
            end
            ALU_AND, ALU_TST: res = in_a & in_b;
            ALU_OR:           res = in_a | in_b;
            ALU_XOR:          res = in_a ^ in_b;
            ALU_MOV:          res = in_b;
            default:          op_def = 1'b0;
        endcase
        sum = {1'b0, in_a} + {1'b0, b_op} + {{XLEN{1'b0}}, cin};
        if (arith) begin
            res = sum[XLEN-1:0];
        end
        flags_d.n = res[XLEN-1];
        flags_d.z = (res == '0);
        flags_d.c = arith ? sum[XLEN] : flags_q.c;
        flags_d.v = arith ? ((in_a[XLEN-1] == b_op[XLEN-1]) && (res[XLEN-1] != in_a[XLEN-1]))
                          : flags_q.v;
    end

    assign accept = in_valid & buf_ready & ~flush;
    assign in_ready = buf_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (accept && in_set_flags && op_def) begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        push_data        = '0;
        push_data.result = res;
        push_data.rd     = in_rd;
        push_data.wb     = alu_writes_reg(op);
    end

    m_alu_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .ready     (buf_ready),
        .push_data (push_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_wb     = head.wb;
    assign out_flags  = flags_q;

endmodule

// File: tb/tb_m_alu_exec_stage.sv
// Scenario bench for m_alu_exec_stage: expected writeback records are queued
// at issue and popped as the head entry is handed to writeback.
module tb_m_alu_exec_stage;
    import p_common::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_set_flags;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wb;
    logic [3:0]  out_flags;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    s_alu_result exp_q[$];
    s_alu_result e;
    logic [31:0] rf [32];

    m_alu_exec_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_set_flags (in_set_flags),
        .in_rd        (in_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wb       (out_wb),
        .out_flags    (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input e_alu_op op, input logic [31:0] a, input logic [31:0] b,
                         input logic sf, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_op        = op;
        in_a         = a;
        in_b         = b;
        in_set_flags = sf;
        in_rd        = rd;
    endtask

    function automatic s_alu_result mk(input logic [31:0] r, input logic [4:0] rd, input logic wb);
        s_alu_result t;
        t.result = r;
        t.rd     = rd;
        t.wb     = wb;
        return t;
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if ({out_result, out_rd, out_wb} !== 38'd0) $display("FAIL reset_out: got %h/%h/%b expected 0", out_result, out_rd, out_wb); else pass_cnt++;
        total_cnt++; if (out_flags !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", out_flags); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_add_overflow;
        @(negedge clk);
        out_ready = 1'b1;
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd1);
        exp_q.push_back(mk(32'h8000_0000, 5'd1, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (!out_valid || exp_q.size() == 0) $display("FAIL add_head: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({out_result, out_rd, out_wb} !== e) $display("FAIL add_head: got %h/%h/%b expected %h/%h/%b", out_result, out_rd, out_wb, e.result, e.rd, e.wb);
            else pass_cnt++;
        end
        total_cnt++; if (out_flags !== 4'b1001) $display("FAIL add_flags: got %b expected 1001", out_flags); else pass_cnt++;
    endtask

    task automatic test_carry_chain;
        @(negedge clk);
        drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd2);
        exp_q.push_back(mk(32'h0, 5'd2, 1'b1));
        @(negedge clk);
        drive(ALU_ADC, 32'h0, 32'h0, 1'b1, 5'd3);
        exp_q.push_back(mk(32'h1, 5'd3, 1'b1));
        total_cnt++;
        if (!out_valid || exp_q.size() == 0) $display("FAIL carry_first: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({out_result, out_rd, out_wb} !== e) $display("FAIL carry_first: got %h/%h/%b expected %h/%h/%b", out_result, out_rd, out_wb, e.result, e.rd, e.wb);
            else pass_cnt++;
        end
        total_cnt++; if (out_flags !== 4'b0110) $display("FAIL carry_flags1: got %b expected 0110", out_flags); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (!out_valid || exp_q.size() == 0) $display("FAIL carry_adc: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({out_result, out_rd, out_wb} !== e) $display("FAIL carry_adc: got %h/%h/%b expected %h/%h/%b", out_result, out_rd, out_wb, e.result, e.rd, e.wb);
            else pass_cnt++;
        end
        total_cnt++; if (out_flags !== 4'b0000) $display("FAIL carry_flags2: got %b expected 0000", out_flags); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int unsigned got;
        logic        wa;
        @(negedge clk);
        out_ready = 1'b0;
        drive(ALU_MOV, 32'h0, 32'd1, 1'b0, 5'd4);
        exp_q.push_back(mk(32'd1, 5'd4, 1'b1));
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready1: got %b expected 1", in_ready); else pass_cnt++;
        drive(ALU_MOV, 32'h0, 32'd2, 1'b0, 5'd5);
        exp_q.push_back(mk(32'd2, 5'd5, 1'b1));
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready2: got %b expected 0", in_ready); else pass_cnt++;
        drive(ALU_MOV, 32'h0, 32'd3, 1'b0, 5'd6);
        exp_q.push_back(mk(32'd3, 5'd6, 1'b1));
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_held: got %b expected 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_result !== 32'd1) $display("FAIL bp_head: got %h expected 1", out_result); else pass_cnt++;
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            if (out_valid) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL bp_order: unexpected output %h", out_result);
                else begin
                    e = exp_q.pop_front();
                    if ({out_result, out_rd, out_wb} !== e) $display("FAIL bp_order: got %h/%h/%b expected %h/%h/%b", out_result, out_rd, out_wb, e.result, e.rd, e.wb);
                    else pass_cnt++;
                end
                got++;
            end
            wa = in_valid && in_ready;
            @(negedge clk);
            if (wa) in_valid = 1'b0;
        end
        total_cnt++; if (got != 3) $display("FAIL bp_count: got %0d outputs expected 3", got); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drained: out_valid=%b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_cmp;
        @(negedge clk);
        out_ready = 1'b1;
        drive(ALU_MOV, 32'h0, 32'd9, 1'b0, 5'd7);
        exp_q.push_back(mk(32'd9, 5'd7, 1'b1));
        @(negedge clk);
        drive(ALU_CMP, 32'd5, 32'd5, 1'b1, 5'd7);
        exp_q.push_back(mk(32'd0, 5'd7, 1'b0));
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            total_cnt++;
            if (!out_valid || exp_q.size() == 0) $display("FAIL cmp_out%0d: out_valid=%b queued=%0d", k, out_valid, exp_q.size());
            else begin
                e = exp_q.pop_front();
                if ({out_result, out_rd, out_wb} !== e) $display("FAIL cmp_out%0d: got %h/%h/%b expected %h/%h/%b", k, out_result, out_rd, out_wb, e.result, e.rd, e.wb);
                else pass_cnt++;
                if (out_wb) rf[out_rd] = out_result;
            end
        end
        total_cnt++; if (out_flags !== 4'b0110) $display("FAIL cmp_flags: got %b expected 0110", out_flags); else pass_cnt++;
        total_cnt++; if (rf[7] !== 32'd9) $display("FAIL cmp_reg: got %h expected 9", rf[7]); else pass_cnt++;
    endtask

    task automatic test_undefined;
        @(negedge clk);
        drive(e_alu_op'(4'hF), 32'd3, 32'd4, 1'b1, 5'd10);
        exp_q.push_back(mk(32'd0, 5'd10, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (!out_valid || exp_q.size() == 0) $display("FAIL undef_out: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({out_result, out_rd, out_wb} !== e) $display("FAIL undef_out: got %h/%h/%b expected %h/%h/%b", out_result, out_rd, out_wb, e.result, e.rd, e.wb);
            else pass_cnt++;
        end
        total_cnt++; if (out_flags !== 4'b0110) $display("FAIL undef_flags: got %b expected 0110", out_flags); else pass_cnt++;
    endtask

    task automatic test_flush;
        @(negedge clk);
        out_ready = 1'b0;
        drive(ALU_MOV, 32'h0, 32'hA, 1'b0, 5'd8);
        @(negedge clk);
        drive(ALU_MOV, 32'h0, 32'hB, 1'b0, 5'd9);
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_full: in_ready=%b expected 0", in_ready); else pass_cnt++;
        drive(ALU_SUB, 32'd1, 32'd2, 1'b1, 5'd11);
        flush = 1'b1;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_flags !== 4'b0110) $display("FAIL flush_flags: got %b expected 0110", out_flags); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b expected 1", in_ready); else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_empty_in: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_flags !== 4'b0110) $display("FAIL flush_sub_flags: got %b expected 0110", out_flags); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        out_ready = 1'b0;
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b expected 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_flags !== 4'b1001) $display("FAIL ar_pre_flags: got %b expected 1001", out_flags); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_flags !== 4'b0000) $display("FAIL ar_flags: got %b expected 0000", out_flags); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL ar_ready: got %b expected 1", in_ready); else pass_cnt++;
        out_ready = 1'b1;
        drive(ALU_MOV, 32'h0, 32'd5, 1'b0, 5'd1);
        exp_q.push_back(mk(32'd5, 5'd1, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (!out_valid || exp_q.size() == 0) $display("FAIL ar_after: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({out_result, out_rd, out_wb} !== e) $display("FAIL ar_after: got %h/%h/%b expected %h/%h/%b", out_result, out_rd, out_wb, e.result, e.rd, e.wb);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_op        = 4'd0;
        in_a         = '0;
        in_b         = '0;
        in_set_flags = 1'b0;
        in_rd        = '0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        for (int r = 0; r < 32; r++) rf[r] = '0;
        test_reset();
        test_add_overflow();
        test_carry_chain();
        test_back_to_back();
        test_cmp();
        test_undefined();
        test_flush();
        test_async_reset();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
